// File: rtl/fetch_controller_pkg.sv
`default_nettype none
// ============================================================================
// fetch_controller_pkg : opcodes, instruction fields and fetch FSM encoding
// Revision: 1.0
// ============================================================================
package fetch_controller_pkg;

   localparam logic [3:0] OP_JMP  = 4'hC;
   localparam logic [3:0] OP_CALL = 4'hD;
   localparam logic [3:0] OP_RET  = 4'hE;

   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 12;
   localparam int TGT_MSB = 11;
   localparam int TGT_LSB = 0;

   typedef enum logic [1:0] {
      ST_START  = 2'd0,
      ST_RUN    = 2'd1,
      ST_SQUASH = 2'd2
   } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_controller_return_stack.sv
`default_nettype none
// ============================================================================
// return_stack : circular return-address stack, oldest entry lost on overflow
// Revision: 1.0
// ============================================================================
module return_stack #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push_i,
   input  logic        pop_i,
   input  logic [15:0] data_i,
   output logic [15:0] data_o,
   output logic        full_o,
   output logic        empty_o
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
   localparam logic [PW:0]   CNT_MAX = (PW+1)'(DEPTH);

   logic [15:0]   mem_q [DEPTH];
   logic [PW-1:0] top_q;
   logic [PW:0]   cnt_q;
   logic [PW-1:0] top_inc;

   assign top_inc = top_q + PTR_ONE;
   assign data_o  = mem_q[top_q];
   assign full_o  = (cnt_q == CNT_MAX);
   assign empty_o = (cnt_q == '0);

   // Pointer wraps freely; a push while full lands on the oldest slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         top_q <= '0;
         cnt_q <= '0;
      end else if (push_i) begin
         top_q <= top_inc;
         if (!full_o) cnt_q <= cnt_q + CNT_ONE;
      end else if (pop_i && !empty_o) begin
         top_q <= top_q - PTR_ONE;
         cnt_q <= cnt_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[top_inc] <= data_i;
   end

endmodule
`default_nettype wire

// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================================
// fetch_controller : PC generation with JMP/CALL/RET decode, optional RAS
// (FETCH_RAS_EN). Revision: 1.0
// ============================================================================
module fetch_controller
   import fetch_controller_pkg::*;
#(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter int          RAS_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        kill,
   input  logic [15:0] redirect_pc,
   input  logic [15:0] instr,
   input  logic [15:0] ret_target,
   output logic [15:0] pc,
   output logic [15:0] fetch_pc,
   output logic        fetch_valid,
   output logic        ras_overflow,
   output logic        ras_underflow
);
   fetch_state_e state_q, state_d;
   logic [15:0]  pc_q, pc_d, fetch_pc_q, fetch_pc_d;
   logic [3:0]   opcode;
   logic         is_jmp, is_call, is_ret, taken, advance;
   logic [15:0]  jump_tgt, ret_pc, target;

   assign pc          = pc_q;
   assign fetch_pc    = fetch_pc_q;
   assign fetch_valid = (state_q == ST_RUN);
   assign advance     = !kill && !stall;

   assign opcode   = instr[OPC_MSB:OPC_LSB];
   assign is_jmp   = fetch_valid && (opcode == OP_JMP);
   assign is_call  = fetch_valid && (opcode == OP_CALL);
   assign is_ret   = fetch_valid && (opcode == OP_RET);
   assign taken    = is_jmp || is_call || is_ret;
   assign jump_tgt = {fetch_pc_q[15:TGT_MSB+1], instr[TGT_MSB:TGT_LSB]};
   assign target   = is_ret ? ret_pc : jump_tgt;

`ifdef FETCH_RAS_EN
   logic [15:0] ras_top;
   logic        ras_full, ras_empty, ras_push, ras_pop;
   logic        ovf_q, udf_q;
   logic        w_unused_ret;

   assign ras_push     = advance && is_call;
   assign ras_pop      = advance && is_ret;
   assign ret_pc       = ras_empty ? RESET_PC : ras_top;
   assign w_unused_ret = ^ret_target;

   return_stack #(.DEPTH(RAS_DEPTH)) u_ras (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (ras_push),
      .pop_i   (ras_pop),
      .data_i  (fetch_pc_q + 16'd2),
      .data_o  (ras_top),
      .full_o  (ras_full),
      .empty_o (ras_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         if (ras_push && ras_full)  ovf_q <= 1'b1;
         if (ras_pop  && ras_empty) udf_q <= 1'b1;
      end
   end

   assign ras_overflow  = ovf_q;
   assign ras_underflow = udf_q;
`else
   logic w_unused_depth;

   assign ret_pc         = ret_target;
   assign ras_overflow   = 1'b0;
   assign ras_underflow  = 1'b0;
   assign w_unused_depth = (RAS_DEPTH == 0);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_START;
         pc_q       <= RESET_PC;
         fetch_pc_q <= RESET_PC;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         fetch_pc_q <= fetch_pc_d;
      end
   end

   // Kill wins over stall; a taken transfer only ever decodes in RUN.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      fetch_pc_d = fetch_pc_q;
      if (kill) begin
         pc_d       = redirect_pc;
         fetch_pc_d = pc_q;
         state_d    = ST_SQUASH;
      end else if (!stall) begin
         fetch_pc_d = pc_q;
         if (taken) begin
            pc_d    = target;
            state_d = ST_SQUASH;
         end else begin
            pc_d    = pc_q + 16'd2;
            state_d = ST_RUN;
         end
      end
   end

endmodule
`default_nettype wire
